// File: rtl/nark_fetch_stage_if.sv
// Signal bundle between the NARK fetch stage, instruction memory, decode and writeback.
// The master modport is the fetch stage; the slave modport is everything around it.
interface nark_fetch_stage_if #(
    parameter int BITS = 24
);
    logic            StallD;
    logic            PCSrcW;
    logic [BITS-1:0] PCTargetW;
    logic            ImemReq;
    logic [BITS-1:0] ImemAddr;
    logic            ImemGnt;
    logic            ImemRValid;
    logic [23:0]     ImemRData;
    logic [23:0]     InstrD;
    logic            InstrValidD;

    modport master (
        input  StallD, PCSrcW, PCTargetW, ImemGnt, ImemRValid, ImemRData,
        output ImemReq, ImemAddr, InstrD, InstrValidD
    );

    modport slave (
        output StallD, PCSrcW, PCTargetW, ImemGnt, ImemRValid, ImemRData,
        input  ImemReq, ImemAddr, InstrD, InstrValidD
    );
endinterface

// File: rtl/nark_fetch_stage.sv
// NARK instruction fetch: PC, in-order variable-latency memory requests, prefetch FIFO,
// and flush handling that discards responses still in flight for the old path.
module nark_fetch_stage #(
    parameter int          BITS   = 24,
    parameter int          DEPTH  = 4,
    parameter int          PC_INC = 1,
    parameter logic [23:0] NOP    = 24'h000000
) (
    input logic                 CLK,
    input logic                 RST,
    nark_fetch_stage_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

    logic [BITS-1:0] pc_reg;
    logic [23:0]     fifo_mem [DEPTH];
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   inflight_reg;
    logic [CW-1:0]   discard_reg;

    logic [CW-1:0]   live;
    logic [CW:0]     occupancy;
    logic            flush;
    logic            req;
    logic            issue;
    logic            resp;
    logic            push;
    logic            valid;
    logic            pop;

    // Every live request owns a FIFO slot in advance, so a returning word always fits.
    assign flush     = bus.PCSrcW;
    assign live      = inflight_reg - discard_reg;
    assign occupancy = {1'b0, live} + {1'b0, count_reg};
    assign req       = ~RST & ~flush & (occupancy < DEPTH_OCC) & (inflight_reg < DEPTH_C);
    assign issue     = req & bus.ImemGnt;
    assign resp      = bus.ImemRValid & (inflight_reg != '0);
    assign push      = resp & (discard_reg == '0) & ~flush;
    assign valid     = (count_reg != '0) & ~flush;
    assign pop       = valid & ~bus.StallD;

    assign bus.ImemReq     = req;
    assign bus.ImemAddr    = pc_reg;
    assign bus.InstrValidD = valid;
    assign bus.InstrD      = valid ? fifo_mem[rd_ptr_reg] : NOP;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_reg       <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            inflight_reg <= '0;
            discard_reg  <= '0;
        end else if (flush) begin
            // Everything still outstanding belongs to the old path; a word landing now is dropped too.
            pc_reg       <= bus.PCTargetW;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            inflight_reg <= inflight_reg - CW'(resp);
            discard_reg  <= inflight_reg - CW'(resp);
        end else begin
            if (issue) begin
                pc_reg <= pc_reg + BITS'(PC_INC);
            end
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg    <= count_reg + CW'(push) - CW'(pop);
            inflight_reg <= inflight_reg + CW'(issue) - CW'(resp);
            if (resp && (discard_reg != '0)) begin
                discard_reg <= discard_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= bus.ImemRData;
        end
    end
endmodule

// File: tb/tb_nark_fetch_stage.sv
// Directed bench for nark_fetch_stage with a variable-latency in-order memory model
// that returns word == address.
module tb_nark_fetch_stage;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    nark_fetch_stage_if #(.BITS(24)) bus ();

    nark_fetch_stage #(
        .BITS(24), .DEPTH(4), .PC_INC(1), .NOP(24'h000000)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int lat       = 1;
    int issue_cnt = 0;
    int iss_base  = 0;
    logic [23:0] exp_instr = 24'h0;
    logic [23:0] q_addr[$];
    int          q_due[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: responses in issue order, one per cycle, 'lat' cycles after issue.
    always @(posedge CLK) begin
        #1;
        cyc++;
        if (RST) begin
            q_addr.delete();
            q_due.delete();
            bus.ImemRValid = 1'b0;
            bus.ImemRData  = 24'h0;
        end else if (q_addr.size() != 0 && q_due[0] <= cyc) begin
            bus.ImemRValid = 1'b1;
            bus.ImemRData  = q_addr.pop_front();
            void'(q_due.pop_front());
        end else begin
            bus.ImemRValid = 1'b0;
            bus.ImemRData  = 24'h0;
        end
    end

    always @(negedge CLK) begin
        if (!RST && bus.ImemReq && bus.ImemGnt) begin
            q_addr.push_back(bus.ImemAddr);
            q_due.push_back(cyc + lat);
            issue_cnt++;
        end
    end

    // One clock cycle: drive inputs after the edge, then check the popped instruction stream.
    task automatic drive_cycle(input logic stall, input logic pcsrc, input logic [23:0] tgt,
                               input logic gnt);
        @(posedge CLK);
        #2;
        bus.StallD    = stall;
        bus.PCSrcW    = pcsrc;
        bus.PCTargetW = tgt;
        bus.ImemGnt   = gnt;
        #1;
        if (bus.InstrValidD && !bus.StallD) begin
            $display("pop instr=%06h", bus.InstrD);
            check("stream", 32'(bus.InstrD), 32'(exp_instr));
            exp_instr = exp_instr + 24'd1;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
        check("rst_req",   32'(bus.ImemReq),     32'd0);
        check("rst_addr",  32'(bus.ImemAddr),    32'd0);
        check("rst_valid", 32'(bus.InstrValidD), 32'd0);
        check("rst_instr", 32'(bus.InstrD),      32'd0);
        RST = 1'b0;
        exp_instr = 24'h0;
    endtask

    initial begin
        #50000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        bus.StallD    = 1'b0;
        bus.PCSrcW    = 1'b0;
        bus.PCTargetW = 24'h0;
        bus.ImemGnt   = 1'b1;

        // Streaming from reset, 1-cycle memory: addresses 0,1,2.., instructions from cycle 3.
        lat = 1;
        do_reset();
        #1;
        check("t1_req0",  32'(bus.ImemReq),  32'd1);
        check("t1_addr0", 32'(bus.ImemAddr), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
            check("t1_addr",  32'(bus.ImemAddr),    32'(k));
            check("t1_valid", 32'(bus.InstrValidD), (k >= 2) ? 32'd1 : 32'd0);
        end

        // Decode stall: FIFO fills to 4 (8..11), requests stop, then resume in order.
        for (int j = 0; j <= 9; j++) begin
            drive_cycle(1'b1, 1'b0, 24'h0, 1'b1);
            if (j == 0) begin
                iss_base = issue_cnt;
                check("t2_req_first",  32'(bus.ImemReq),  32'd1);
                check("t2_addr_first", 32'(bus.ImemAddr), 32'd10);
            end
            if (j >= 2) check("t2_req_off", 32'(bus.ImemReq), 32'd0);
        end
        check("t2_issues",     32'(issue_cnt - iss_base), 32'd2);
        check("t2_hold_valid", 32'(bus.InstrValidD),      32'd1);
        check("t2_hold_instr", 32'(bus.InstrD),           32'h8);
        drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
        check("t2_req_release", 32'(bus.ImemReq), 32'd0);
        drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
        check("t2_req_resume",  32'(bus.ImemReq),  32'd1);
        check("t2_addr_resume", 32'(bus.ImemAddr), 32'd12);
        repeat (6) drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);

        // Grant withheld for 3 cycles: address held, then fetched exactly once.
        for (int g = 0; g < 3; g++) begin
            drive_cycle(1'b0, 1'b0, 24'h0, 1'b0);
            check("t3_req_hold",  32'(bus.ImemReq),  32'd1);
            check("t3_addr_hold", 32'(bus.ImemAddr), 32'd19);
        end
        drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
        check("t3_addr_gnt", 32'(bus.ImemAddr), 32'd19);
        drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
        check("t3_addr_next", 32'(bus.ImemAddr), 32'd20);
        repeat (4) drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);

        // Flush with 3 requests in flight on a 4-cycle memory: all three old words dropped.
        lat = 4;
        do_reset();
        drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
        drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
        drive_cycle(1'b0, 1'b1, 24'h000100, 1'b1);
        check("t4_req_flush", 32'(bus.ImemReq), 32'd0);
        exp_instr = 24'h000100;
        drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
        check("t4_addr_tgt", 32'(bus.ImemAddr),    32'h100);
        check("t4_valid_k4", 32'(bus.InstrValidD), 32'd0);
        for (int k = 5; k <= 8; k++) begin
            drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
            check("t4_valid_drop", 32'(bus.InstrValidD), 32'd0);
        end
        drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
        check("t4_valid_tgt", 32'(bus.InstrValidD), 32'd1);
        repeat (6) drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);

        // Flush coinciding with a response and a would-be pop.
        lat = 1;
        do_reset();
        drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
        drive_cycle(1'b0, 1'b1, 24'h000200, 1'b1);
        check("t5_valid_flush", 32'(bus.InstrValidD), 32'd0);
        check("t5_instr_flush", 32'(bus.InstrD),      32'd0);
        check("t5_req_flush",   32'(bus.ImemReq),     32'd0);
        exp_instr = 24'h000200;
        drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
        check("t5_addr_tgt", 32'(bus.ImemAddr),    32'h200);
        check("t5_valid_k3", 32'(bus.InstrValidD), 32'd0);
        drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
        check("t5_valid_k4", 32'(bus.InstrValidD), 32'd0);
        drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
        check("t5_valid_k5", 32'(bus.InstrValidD), 32'd1);
        repeat (2) drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);

        // Back-to-back flushes (last target wins) into the top of the address space.
        drive_cycle(1'b0, 1'b1, 24'h000300, 1'b1);
        drive_cycle(1'b0, 1'b1, 24'hFFFFFF, 1'b1);
        exp_instr = 24'hFFFFFF;
        drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
        check("t6_addr_top",  32'(bus.ImemAddr), 32'hFFFFFF);
        drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
        check("t6_addr_wrap", 32'(bus.ImemAddr), 32'h000000);
        repeat (5) drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);

        // Asynchronous reset mid-burst, then a clean restart from address 0.
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        check("t7_async_req",   32'(bus.ImemReq),     32'd0);
        check("t7_async_addr",  32'(bus.ImemAddr),    32'd0);
        check("t7_async_valid", 32'(bus.InstrValidD), 32'd0);
        check("t7_async_instr", 32'(bus.InstrD),      32'd0);
        do_reset();
        #1;
        check("t7_restart_req", 32'(bus.ImemReq), 32'd1);
        drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
        check("t7_addr1", 32'(bus.ImemAddr), 32'd1);
        drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);
        check("t7_valid2", 32'(bus.InstrValidD), 32'd1);
        check("t7_instr2", 32'(bus.InstrD),      32'd0);
        repeat (3) drive_cycle(1'b0, 1'b0, 24'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
